// File: rtl/prio_issue_scheduler.sv
// Out-of-order issue scheduler: lowest-index-first allocation and selection,
// one tag-tracked source operand per entry, entries retire on port handshake.
module prio_issue_scheduler #(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 2,
    parameter int SEL_WIDTH = 2,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush_i,
    input  logic [ENQ_WIDTH-1:0]           enq_vld_i,
    input  logic [ENQ_WIDTH*DATA_W-1:0]    enq_data_i,
    input  logic [ENQ_WIDTH-1:0]           enq_src_rdy_i,
    input  logic [ENQ_WIDTH*TAG_W-1:0]     enq_src_tag_i,
    output logic [ENQ_WIDTH-1:0]           enq_rdy_o,
    input  logic                           wakeup_vld_i,
    input  logic [TAG_W-1:0]               wakeup_tag_i,
    output logic [SEL_WIDTH-1:0]           iss_vld_o,
    output logic [SEL_WIDTH*DATA_W-1:0]    iss_data_o,
    input  logic [SEL_WIDTH-1:0]           iss_rdy_i,
    output logic [$clog2(DEPTH):0]         count_o,
    output logic                           empty_o,
    output logic                           full_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_rdy;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic [CNT_W-1:0]  w_free;
    logic [IDX_W-1:0]  w_enq_idx [ENQ_WIDTH];
    logic [IDX_W-1:0]  w_sel_idx [SEL_WIDTH];
    logic [ENQ_WIDTH-1:0] w_enq_fire;
    logic [SEL_WIDTH-1:0] w_iss_fire;
    logic [DEPTH-1:0]  w_cand;
    logic [DEPTH-1:0]  w_vld_nxt;
    logic [DEPTH-1:0]  w_rdy_nxt;
    logic [CNT_W-1:0]  w_enq_cnt;
    logic [CNT_W-1:0]  w_iss_cnt;

    // Lane readiness comes from the registered count only, so nothing upstream can loop back.
    assign w_free = CNT_W'(DEPTH) - r_count;
    always_comb begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            enq_rdy_o[k] = (w_free > CNT_W'(k));
        end
    end

    assign w_enq_fire = enq_vld_i & enq_rdy_o;
    assign w_iss_fire = iss_vld_o & iss_rdy_i;
    assign w_cand     = r_vld & r_rdy;

    // Lane k takes the (k+1)-th free slot regardless of which lower lanes are valid.
    always_comb begin
        int n_seen;
        // NOTE: every combinational output gets a default before the loops; otherwise a latch is inferred.
        n_seen = 0;
        for (int k = 0; k < ENQ_WIDTH; k++) w_enq_idx[k] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_vld[i]) begin
                for (int k = 0; k < ENQ_WIDTH; k++) begin
                    if (n_seen == k) w_enq_idx[k] = IDX_W'(i);
                end
                n_seen++;
            end
        end
    end

    always_comb begin
        int n_seen;
        n_seen    = 0;
        iss_vld_o = '0;
        for (int j = 0; j < SEL_WIDTH; j++) w_sel_idx[j] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_cand[i]) begin
                for (int j = 0; j < SEL_WIDTH; j++) begin
                    if (n_seen == j) begin
                        w_sel_idx[j] = IDX_W'(i);
                        iss_vld_o[j] = 1'b1;
                    end
                end
                n_seen++;
            end
        end
        for (int j = 0; j < SEL_WIDTH; j++) begin
            iss_data_o[j*DATA_W +: DATA_W] = iss_vld_o[j] ? r_data[w_sel_idx[j]] : '0;
        end
    end

    // Enqueue targets only free slots and issue only occupied ones, so the two never collide.
    always_comb begin
        w_vld_nxt = r_vld;
        w_rdy_nxt = r_rdy;
        w_enq_cnt = '0;
        w_iss_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wakeup_vld_i && r_vld[i] && (r_tag[i] == wakeup_tag_i)) w_rdy_nxt[i] = 1'b1;
        end
        for (int j = 0; j < SEL_WIDTH; j++) begin
            if (w_iss_fire[j]) begin
                w_vld_nxt[w_sel_idx[j]] = 1'b0;
                w_rdy_nxt[w_sel_idx[j]] = 1'b0;
                w_iss_cnt = w_iss_cnt + CNT_W'(1);
            end
        end
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (w_enq_fire[k]) begin
                w_vld_nxt[w_enq_idx[k]] = 1'b1;
                w_rdy_nxt[w_enq_idx[k]] = enq_src_rdy_i[k] |
                    (wakeup_vld_i && (enq_src_tag_i[k*TAG_W +: TAG_W] == wakeup_tag_i));
                w_enq_cnt = w_enq_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_rdy   <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_vld   <= '0;
            r_rdy   <= '0;
            r_count <= '0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_rdy   <= w_rdy_nxt;
            r_count <= r_count + w_enq_cnt - w_iss_cnt;
        end
    end

    // NOTE: payload and tag storage is never read unless r_vld is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (w_enq_fire[k]) begin
                r_data[w_enq_idx[k]] <= enq_data_i[k*DATA_W +: DATA_W];
                r_tag[w_enq_idx[k]]  <= enq_src_tag_i[k*TAG_W +: TAG_W];
            end
        end
    end

    assign count_o = r_count;
    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_prio_issue_scheduler.sv
// Self-checking bench for prio_issue_scheduler: a vector table for the basic
// enqueue/wakeup/select cases, hand sequences for fill, sparse select, flush and reset.
module tb_prio_issue_scheduler;

    localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
    localparam logic [31:0] B5 = 32'hB000_0005, B7 = 32'hB000_0007;
    localparam logic [31:0] C3 = 32'hC000_0003, D1 = 32'hD000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [1:0]  enq_vld_i;
    logic [63:0] enq_data_i;
    logic [1:0]  enq_src_rdy_i;
    logic [7:0]  enq_src_tag_i;
    logic [1:0]  enq_rdy_o;
    logic        wakeup_vld_i;
    logic [3:0]  wakeup_tag_i;
    logic [1:0]  iss_vld_o;
    logic [63:0] iss_data_o;
    logic [1:0]  iss_rdy_i;
    logic [3:0]  count_o;
    logic        empty_o;
    logic        full_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [1:0]  enq_vld;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  src_rdy;
        logic [3:0]  tag0;
        logic [3:0]  tag1;
        logic        wake_vld;
        logic [3:0]  wake_tag;
        logic [1:0]  iss_rdy;
        logic [1:0]  exp_vld;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [3:0]  exp_cnt;
        logic [1:0]  exp_erdy;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    prio_issue_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .enq_vld_i     (enq_vld_i),
        .enq_data_i    (enq_data_i),
        .enq_src_rdy_i (enq_src_rdy_i),
        .enq_src_tag_i (enq_src_tag_i),
        .enq_rdy_o     (enq_rdy_o),
        .wakeup_vld_i  (wakeup_vld_i),
        .wakeup_tag_i  (wakeup_tag_i),
        .iss_vld_o     (iss_vld_o),
        .iss_data_o    (iss_data_o),
        .iss_rdy_i     (iss_rdy_i),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] vld, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [3:0] cnt, input logic [1:0] erdy);
        check({name, "_iss_vld"}, 64'(iss_vld_o), 64'(vld));
        check({name, "_iss_d0"}, 64'(iss_data_o[31:0]), 64'(d0));
        check({name, "_iss_d1"}, 64'(iss_data_o[63:32]), 64'(d1));
        check({name, "_count"}, 64'(count_o), 64'(cnt));
        check({name, "_enq_rdy"}, 64'(enq_rdy_o), 64'(erdy));
        check({name, "_empty"}, 64'(empty_o), 64'(cnt == 4'd0));
        check({name, "_full"}, 64'(full_o), 64'(cnt == 4'd8));
    endtask

    task automatic set_in(input logic [1:0] ev, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] sr, input logic [3:0] t0, input logic [3:0] t1,
                          input logic wv, input logic [3:0] wt, input logic [1:0] ir, input logic fl);
        enq_vld_i     = ev;
        enq_data_i    = {b, a};
        enq_src_rdy_i = sr;
        enq_src_tag_i = {t1, t0};
        wakeup_vld_i  = wv;
        wakeup_tag_i  = wt;
        iss_rdy_i     = ir;
        flush_i       = fl;
    endtask

    task automatic idle();
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
    endtask

    // Handshakes are scored mid-cycle against the expected-issue queue, then the edge is taken.
    task automatic tick();
        logic [31:0] e;
        #3;
        for (int j = 0; j < 2; j++) begin
            if (rst_n && iss_vld_o[j] && iss_rdy_i[j]) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_lane%0d: got issue %0h, expected none", j, iss_data_o[j*32 +: 32]);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("sb_lane%0d", j), 64'(iss_data_o[j*32 +: 32]), 64'(e));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b11, A0, A1, 2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00, '0, '0, 4'd0, 2'b11};
        vecs[1]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b11, 2'b11, A0, A1, 4'd2, 2'b11};
        vecs[2]  = '{2'b11, B5, B7, 2'b00, 4'd5, 4'd7, 1'b0, 4'd0, 2'b11, 2'b00, '0, '0, 4'd0, 2'b11};
        vecs[3]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 2'b11, 2'b00, '0, '0, 4'd2, 2'b11};
        vecs[4]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b11, 2'b01, B7, '0, 4'd2, 2'b11};
        vecs[5]  = '{2'b01, C3, '0, 2'b00, 4'd3, 4'd0, 1'b1, 4'd3, 2'b11, 2'b00, '0, '0, 4'd1, 2'b11};
        vecs[6]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b11, 2'b01, C3, '0, 4'd2, 2'b11};
        vecs[7]  = '{2'b10, '0, D1, 2'b10, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00, '0, '0, 4'd1, 2'b11};
        vecs[8]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b01, D1, '0, 4'd2, 2'b11};
        vecs[9]  = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd5, 2'b00, 2'b01, D1, '0, 4'd2, 2'b11};
        vecs[10] = '{2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b11, 2'b11, B5, D1, 4'd2, 2'b11};

        rst_n = 1'b0;
        idle();
        #2;
        check_outs("reset", 2'b00, '0, '0, 4'd0, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            check_outs($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_d0, vecs[i].exp_d1,
                       vecs[i].exp_cnt, vecs[i].exp_erdy);
            set_in(vecs[i].enq_vld, vecs[i].d0, vecs[i].d1, vecs[i].src_rdy, vecs[i].tag0,
                   vecs[i].tag1, vecs[i].wake_vld, vecs[i].wake_tag, vecs[i].iss_rdy, 1'b0);
            if (vecs[i].exp_vld[0] && vecs[i].iss_rdy[0]) sb_q.push_back(vecs[i].exp_d0);
            if (vecs[i].exp_vld[1] && vecs[i].iss_rdy[1]) sb_q.push_back(vecs[i].exp_d1);
            tick();
        end
        idle();
        check_outs("post_vec", 2'b00, '0, '0, 4'd0, 2'b11);

        // Fill all eight slots with waiting entries, then show that further enqueues are dropped.
        for (int c = 0; c < 4; c++) begin
            set_in(2'b11, 32'hF000_0000 + 32'(2*c), 32'hF000_0001 + 32'(2*c), 2'b00,
                   4'd9, 4'd9, 1'b0, 4'd0, 2'b00, 1'b0);
            tick();
        end
        idle();
        check_outs("full", 2'b00, '0, '0, 4'd8, 2'b00);
        set_in(2'b11, 32'hDEAD_0000, 32'hDEAD_0001, 2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("drop", 2'b00, '0, '0, 4'd8, 2'b00);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd9, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("woken", 2'b11, 32'hF000_0000, 32'hF000_0001, 4'd8, 2'b00);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b01, 1'b0);
        sb_q.push_back(32'hF000_0000);
        tick();
        idle();
        check_outs("one_free", 2'b11, 32'hF000_0001, 32'hF000_0002, 4'd7, 2'b01);
        set_in(2'b11, 32'h6000_0000, 32'hDEAD_0002, 2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("refill", 2'b11, 32'h6000_0000, 32'hF000_0001, 4'd8, 2'b00);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b1);
        tick();
        idle();
        check_outs("flush1", 2'b00, '0, '0, 4'd0, 2'b11);

        // Only entries 2, 4, 6 ready; entry 7 waits on tag 10, the rest on tag 9.
        set_in(2'b11, 32'h5000_0000, 32'h5000_0001, 2'b00, 4'd9, 4'd9, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        set_in(2'b11, 32'h5000_0002, 32'h5000_0003, 2'b01, 4'd9, 4'd9, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        set_in(2'b11, 32'h5000_0004, 32'h5000_0005, 2'b01, 4'd9, 4'd9, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        set_in(2'b11, 32'h5000_0006, 32'h5000_0007, 2'b01, 4'd9, 4'd10, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("sparse", 2'b11, 32'h5000_0002, 32'h5000_0004, 4'd8, 2'b00);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b10, 1'b0);
        sb_q.push_back(32'h5000_0004);
        tick();
        idle();
        check_outs("hold_low", 2'b11, 32'h5000_0002, 32'h5000_0006, 4'd7, 2'b01);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b11, 1'b0);
        sb_q.push_back(32'h5000_0002);
        sb_q.push_back(32'h5000_0006);
        tick();
        idle();
        check_outs("five", 2'b00, '0, '0, 4'd5, 2'b11);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd10, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("w10", 2'b01, 32'h5000_0007, '0, 4'd5, 2'b11);
        set_in(2'b01, 32'h7000_0000, '0, 2'b01, 4'd0, 4'd0, 1'b0, 4'd0, 2'b01, 1'b1);
        sb_q.push_back(32'h5000_0007);
        tick();
        idle();
        check_outs("flush2", 2'b00, '0, '0, 4'd0, 2'b11);

        // Asynchronous reset between clock edges, then normal operation after release.
        set_in(2'b11, 32'h8000_0000, 32'h8000_0001, 2'b11, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("pre_rst", 2'b11, 32'h8000_0000, 32'h8000_0001, 4'd2, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, '0, '0, 4'd0, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_rst", 2'b00, '0, '0, 4'd0, 2'b11);
        set_in(2'b01, 32'h9000_0000, '0, 2'b01, 4'd0, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0);
        tick();
        idle();
        check_outs("resume", 2'b01, 32'h9000_0000, '0, 4'd1, 2'b11);
        set_in(2'b00, '0, '0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 2'b01, 1'b0);
        sb_q.push_back(32'h9000_0000);
        tick();
        idle();
        check_outs("drained", 2'b00, '0, '0, 4'd0, 2'b11);
        check("sb_left", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
